// File: rtl/mem_write_sink_if.sv
// Write and read handshake bundle between the ALU data-write port and mem_write_sink.
// A transfer happens on a rising edge where valid and ready are both high. Valid never waits on ready.
interface mem_write_sink_if #(
  parameter int mem_addr_width = 16,
  parameter int data_width     = 32
);
  logic                      w_valid_i;
  logic [mem_addr_width-1:0] w_addr_i;
  logic [data_width-1:0]     w_write_i;
  logic                      w_ready_o;
  logic                      r_valid_i;
  logic [mem_addr_width-1:0] r_addr_i;
  logic                      r_ready_o;
  logic [data_width-1:0]     r_data_o;
  logic                      r_data_valid_o;

  modport master (
    output w_valid_i, w_addr_i, w_write_i, r_valid_i, r_addr_i,
    input  w_ready_o, r_ready_o, r_data_o, r_data_valid_o
  );

  modport slave (
    input  w_valid_i, w_addr_i, w_write_i, r_valid_i, r_addr_i,
    output w_ready_o, r_ready_o, r_data_o, r_data_valid_o
  );
endinterface

// File: rtl/mem_write_sink.sv
// Buffers ALU word writes in an in-order FIFO, drains them into a data RAM and
// serves one read port that stalls while a same-address write is still buffered.
module mem_write_sink #(
  parameter int mem_addr_width = 16,
  parameter int data_width     = 32,
  parameter int mem_words      = 1024,
  parameter int fifo_depth     = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  mem_write_sink_if.slave               bus,
  output logic [$clog2(fifo_depth):0]   level_o,
  output logic                          idle_o,
  output logic                          err_o
);
  localparam int ptr_w  = $clog2(fifo_depth);
  localparam int lvl_w  = ptr_w + 1;
  localparam int ram_aw = $clog2(mem_words);
  localparam logic [mem_addr_width:0] addr_lim = (mem_addr_width + 1)'(mem_words);
  localparam logic [lvl_w-1:0]        full_lvl = lvl_w'(fifo_depth);

  logic [mem_addr_width-1:0] q_addr [fifo_depth];
  logic [data_width-1:0]     q_data [fifo_depth];
  logic [ptr_w-1:0]          wr_ptr, rd_ptr;
  logic [lvl_w-1:0]          level, level_nxt;
  logic [data_width-1:0]     ram [mem_words];
  logic [data_width-1:0]     r_data;
  logic                      r_data_valid, idle, err;
  logic                      hazard, full, push, rd_acc, pop;
  logic                      head_in_range, rd_in_range;
  logic [ptr_w-1:0]          off;

  // An entry is live when its distance from the head is below the level.
  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < fifo_depth; i++) begin
      off = ptr_w'(i) - rd_ptr;
      if (({1'b0, off} < level) && (q_addr[i] == bus.r_addr_i)) hazard = 1'b1;
    end
  end

  assign full          = (level == full_lvl);
  assign bus.w_ready_o = !reset_i && !full;
  assign bus.r_ready_o = !reset_i && !full && !hazard;
  assign push          = bus.w_valid_i && bus.w_ready_o;
  assign rd_acc        = bus.r_valid_i && bus.r_ready_o;
  // Reads win the RAM port except when the buffer is full.
  assign pop           = (level != '0) && (!rd_acc || full);
  assign head_in_range = ({1'b0, q_addr[rd_ptr]} < addr_lim);
  assign rd_in_range   = ({1'b0, bus.r_addr_i} < addr_lim);
  assign level_nxt     = level + lvl_w'(push) - lvl_w'(pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      idle         <= 1'b1;
      err          <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (push) begin
        q_addr[wr_ptr] <= bus.w_addr_i;
        q_data[wr_ptr] <= bus.w_write_i;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (!head_in_range) err <= 1'b1;
      end
      level        <= level_nxt;
      idle         <= (level_nxt == '0);
      r_data_valid <= rd_acc;
      if (rd_acc) begin
        r_data <= rd_in_range ? ram[bus.r_addr_i[ram_aw-1:0]] : '0;
        if (!rd_in_range) err <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; out-of-range heads are dropped here.
  always_ff @(posedge clk_i) begin
    if (!reset_i && pop && head_in_range)
      ram[q_addr[rd_ptr][ram_aw-1:0]] <= q_data[rd_ptr];
  end

  assign bus.r_data_o       = r_data;
  assign bus.r_data_valid_o = r_data_valid;
  assign level_o            = level;
  assign idle_o             = idle;
  assign err_o              = err;
endmodule

// File: tb/tb_mem_write_sink.sv
// Bench for mem_write_sink: directed scenarios plus random traffic against a
// reference where every accepted read sees all previously accepted writes.
module tb_mem_write_sink;
  localparam int aw = 16, dw = 32, words = 1024, depth = 4;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [2:0] level_o;
  logic       idle_o, err_o;

  mem_write_sink_if #(.mem_addr_width(aw), .data_width(dw)) bus();

  mem_write_sink #(.mem_addr_width(aw), .data_width(dw), .mem_words(words), .fifo_depth(depth)) dut (
    .clk_i(clk), .reset_i(reset_i), .bus(bus),
    .level_o(level_o), .idle_o(idle_o), .err_o(err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int              n_checks = 0, n_fail = 0;
  logic [dw-1:0]   exp_q[$];
  logic [dw-1:0]   mem_m [int];
  logic            exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_range(input logic [aw-1:0] a);
    return int'(a) < words;
  endfunction

  function automatic logic [dw-1:0] model_read(input logic [aw-1:0] a);
    if (!in_range(a)) return '0;
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return 'x;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives, samples readies just before the edge, returns at next posedge+1.
  task automatic drive_cycle(input logic wv, input logic [aw-1:0] wa, input logic [dw-1:0] wd,
                             input logic rv, input logic [aw-1:0] ra,
                             output logic w_rdy, output logic r_rdy,
                             output logic w_acc, output logic r_acc);
    bus.w_valid_i = wv; bus.w_addr_i = wa; bus.w_write_i = wd;
    bus.r_valid_i = rv; bus.r_addr_i = ra;
    #7;
    w_rdy = bus.w_ready_o; r_rdy = bus.r_ready_o;
    w_acc = wv && w_rdy;   r_acc = rv && r_rdy;
    if (r_acc) begin
      exp_q.push_back(model_read(ra));
      if (!in_range(ra)) exp_err = 1'b1;
    end
    if (w_acc) begin
      if (in_range(wa)) mem_m[int'(wa)] = wd;
      else exp_err = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic write1(input logic [aw-1:0] a, input logic [dw-1:0] d);
    logic wr, rr, wa, ra;
    drive_cycle(1'b1, a, d, 1'b0, '0, wr, rr, wa, ra);
    check("write_accept", wa, 1'b1);
  endtask

  task automatic read1(input logic [aw-1:0] a);
    logic wr, rr, wa, ra;
    int n = 0;
    do begin
      drive_cycle(1'b0, '0, '0, 1'b1, a, wr, rr, wa, ra);
      n++;
    end while (!ra && n < 20);
    check("read_accept", ra, 1'b1);
  endtask

  task automatic idle_cycle();
    logic wr, rr, wa, ra;
    drive_cycle(1'b0, '0, '0, 1'b0, '0, wr, rr, wa, ra);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) idle_cycle();
    while (!idle_o && n < 20) begin
      idle_cycle();
      n++;
    end
    check("drain_idle", idle_o, 1'b1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.r_data_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("rdata_unexpected", 1'b1, 1'b0);
      else check("rdata", bus.r_data_o, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic wr, rr, wa, ra;
    logic [dw-1:0] old_v [3];
    int wk;

    bus.w_valid_i = 1'b0; bus.w_addr_i = '0; bus.w_write_i = '0;
    bus.r_valid_i = 1'b0; bus.r_addr_i = '0;
    @(posedge clk); #1;
    drive_cycle(1'b1, 16'd1, 32'h1, 1'b1, 16'd1, wr, rr, wa, ra);
    check("reset_w_ready", wr, 1'b0);
    check("reset_r_ready", rr, 1'b0);
    idle_cycle();
    reset_i = 1'b0;
    check("reset_level", level_o, 3'd0);
    check("reset_idle", idle_o, 1'b1);
    check("reset_err", err_o, 1'b0);
    check("reset_rvalid", bus.r_data_valid_o, 1'b0);
    check("reset_rdata", bus.r_data_o, 32'h0);

    for (int a = 0; a < 32; a++) write1(16'(a), $urandom);
    wait_idle();

    // Basic write then read with a one-cycle gap.
    write1(16'd5, 32'hDEADBEEF);
    idle_cycle();
    read1(16'd5);
    check("t1_rvalid_pulse", bus.r_data_valid_o, 1'b1);
    check("t1_rdata", bus.r_data_o, 32'hDEADBEEF);
    idle_cycle();
    check("t1_rvalid_drop", bus.r_data_valid_o, 1'b0);
    check("t1_rdata_hold", bus.r_data_o, 32'hDEADBEEF);
    check("t1_level", level_o, 3'd0);
    check("t1_idle", idle_o, 1'b1);

    // Sustained reads starve the drain until the buffer fills.
    for (int k = 1; k <= 4; k++) begin
      drive_cycle(1'b1, 16'(k), 32'h100 + 32'(k), 1'b1, 16'd0, wr, rr, wa, ra);
      check("t2_push", wa, 1'b1);
      check("t2_read", ra, 1'b1);
    end
    check("t2_level_full", level_o, 3'd4);
    drive_cycle(1'b1, 16'd6, 32'h66, 1'b1, 16'd0, wr, rr, wa, ra);
    check("t2_full_w_ready", wr, 1'b0);
    check("t2_full_r_ready", rr, 1'b0);
    check("t2_level_after_pop", level_o, 3'd3);
    drive_cycle(1'b0, 16'd6, 32'h66, 1'b0, 16'd0, wr, rr, wa, ra);
    check("t2_w_ready_again", wr, 1'b1);
    check("t2_r_ready_again", rr, 1'b1);
    wait_idle();
    for (int k = 1; k <= 4; k++) read1(16'(k));

    // Read hazard against a buffered write to the same address.
    write1(16'd9, 32'h11);
    drive_cycle(1'b0, '0, '0, 1'b1, 16'd9, wr, rr, wa, ra);
    check("t3_hazard_stall", rr, 1'b0);
    read1(16'd9);

    // Last of repeated writes wins.
    write1(16'd3, 32'hA); write1(16'd3, 32'hB); write1(16'd3, 32'hC);
    wait_idle();
    read1(16'd3);

    // Out-of-range write and read.
    write1(16'd1024, 32'h55);
    wait_idle();
    check("t5_err_write", err_o, 1'b1);
    read1(16'd2000);
    idle_cycle();
    check("t5_oor_rdata", bus.r_data_o, 32'h0);
    check("t5_err_sticky", err_o, 1'b1);

    // Reset with three undrained writes.
    for (int k = 0; k < 3; k++) old_v[k] = mem_m[20 + k];
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 16'(20 + k), 32'hBAD0 + 32'(k), 1'b1, 16'd0, wr, rr, wa, ra);
      check("t6_push", wa, 1'b1);
    end
    check("t6_level3", level_o, 3'd3);
    reset_i = 1'b1;
    idle_cycle();
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) mem_m[20 + k] = old_v[k];
    exp_err = 1'b0;
    check("t6_level", level_o, 3'd0);
    check("t6_idle", idle_o, 1'b1);
    check("t6_err", err_o, 1'b0);
    check("t6_rvalid", bus.r_data_valid_o, 1'b0);
    for (int k = 0; k < 3; k++) read1(16'(20 + k));

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [aw-1:0] wad, rad;
      wad = ($urandom_range(0, 39) == 0) ? 16'(1024 + $urandom_range(0, 64511)) : 16'($urandom_range(0, 31));
      rad = ($urandom_range(0, 39) == 0) ? 16'(1024 + $urandom_range(0, 64511)) : 16'($urandom_range(0, 31));
      wk  = $urandom_range(0, 9);
      drive_cycle(wk < 6, wad, $urandom, $urandom_range(0, 9) < 7, rad, wr, rr, wa, ra);
    end
    wait_idle();
    check("final_err", err_o, exp_err);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_write_sink.md
# mem_write_sink

Memory-side responder for the ALU's data-write port. It accepts word writes over a valid/ready handshake and buffers them in a small in-order FIFO. It drains the FIFO into an internal word-addressed data RAM and also serves a single read port. Reads are blocked while a buffered write to the same address is still pending. It sits between the ALU write port (w_valid/w_addr/w_write) and the shader data memory.

## Interface
- mem_addr_width, 16, width of write/read addresses.
- data_width, 32, word width (`REG_WIDTH`).
- mem_words, 1024, number of RAM words. Valid addresses are 0..mem_words-1.
- fifo_depth, 4, write-buffer entries. Must be a power of two and ≥2.
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- w_valid_i  in  1  write request present.
- w_addr_i  in  mem_addr_width  write word address.
- w_write_i  in  data_width  write data.
- w_ready_o  out  1  write can be accepted this cycle.
- r_valid_i  in  1  read request present.
- r_addr_i  in  mem_addr_width  read word address.
- r_ready_o  out  1  read can be accepted this cycle.
- r_data_o  out  data_width  read result.
- r_data_valid_o  out  1  r_data_o holds a new result this cycle.
- level_o  out  $clog2(fifo_depth)+1  number of buffered writes.
- idle_o  out  1  FIFO empty.
- err_o  out  1  sticky flag: an out-of-range address was seen.

## Operation
- **Write accept:** a write is accepted on a cycle with w_valid_i && w_ready_o.
  - w_ready_o = !reset_i && (level < fifo_depth).
  - An accepted write is pushed at the FIFO tail: {addr, data}.
- **Drain:** each cycle at most one head entry is popped and written to RAM. The head pops when the FIFO is non-empty and either:
  - no read is accepted this cycle, or
  - level == fifo_depth (drain priority).
- **Out-of-range drain:** an entry with addr ≥ mem_words is popped and discarded; err_o is set.
- **Read accept:** a read is accepted on r_valid_i && r_ready_o.
  - r_ready_o = !reset_i && (level < fifo_depth) && !hazard.
  - hazard = some valid FIFO entry has addr == r_addr_i. The comparison is over the full address width.
- **Read data:** an accepted read samples the RAM. Out-of-range reads return 0 and set err_o.
- **Same-cycle ordering:** a read accepted in the same cycle as a write push is ordered before that write. It returns the pre-write RAM value.
- **Simultaneous push and pop:** level is unchanged. Pointers wrap modulo fifo_depth.
- **FIFO order:** writes commit to RAM strictly in acceptance order. Repeated writes to one address leave the last value.
- **err_o:** cleared only by reset.
- **Reset:** RAM contents are not reset.

## Timing
- **Reset values:**
  - w_ready_o = 0 and r_ready_o = 0 while reset_i is high.
  - Registered outputs: r_data_o = 0, r_data_valid_o = 0, level_o = 0, idle_o = 1, err_o = 0.
  - FIFO pointers are zeroed.
- **Reset mid-operation:** buffered, undrained writes are discarded. A read result due the following cycle is suppressed (r_data_valid_o = 0).
- **Write-to-RAM latency:** an accepted write into an empty FIFO with no competing read is popped on the next edge. It is visible to a read accepted 2 cycles after the write was accepted.
- **Read latency:** 1 cycle. Read accepted at edge N gives r_data_o/r_data_valid_o valid in cycle N+1. r_data_valid_o is a one-cycle pulse per accepted read. r_data_o holds its value until the next read.
- **Throughput:**
  - 1 write per cycle when the FIFO is not full.
  - 1 read per cycle when there is no hazard and the FIFO is not full.
  - Sustained reads stall the drain until the FIFO fills. Then reads stall for one pop.
- **Output timing:** level_o and idle_o are registered and reflect post-edge state. w_ready_o and r_ready_o are combinational from registered level and current r_addr_i.

## Test plan
- Write addr 5 data 0xDEADBEEF, idle 1 cycle, read addr 5 -> r_data_valid_o pulses 1 cycle after accept with r_data_o = 0xDEADBEEF; level_o returns 0, idle_o = 1.
- Continuous r_valid_i to addr 0 while pushing 4 writes (fifo_depth=4) to addrs 1..4 -> level_o reaches 4, w_ready_o = 0 and r_ready_o = 0 for that cycle, one pop occurs, then both ready again.
- Write addr 9 = 0x11 then immediately read addr 9 -> r_ready_o = 0 until entry drains; read then returns 0x11, never the stale value.
- Writes to addr 3 of 0xA, 0xB, 0xC back-to-back -> after drain, read addr 3 returns 0xC.
- Write addr mem_words (1024) data 0x55 -> entry drains, err_o = 1 and stays 1; read addr 2000 -> r_data_o = 0, err_o = 1.
- Fill FIFO with 3 entries then assert reset_i for 1 cycle -> level_o = 0, idle_o = 1, err_o = 0, r_data_valid_o = 0; subsequent reads of those addresses return prior RAM contents.
